tok_ocpl_target: RTL and testbench

Token-target endpoint terminating the OCP-lite token master port that the NoC token network drives towards a block (APU and peers). It accepts token write commands, accumulates tokens per line in saturation-safe counters, exposes token availability to local consumers and supports the NoC idle request/acknowledge power handshake. It sits on the block side of the `*_targ_tok_ocpl_m_*` link, in the block clock domain.

---
 rtl/tok_ocpl_pkg.sv | 22 ++
 rtl/tok_ocpl_cnt.sv | 41 ++++
 rtl/tok_ocpl_target.sv | 155 +++++++++++++++
 tb/tb_tok_ocpl_target.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tok_ocpl_pkg.sv
// Shared constants and types for the OCP-lite token target endpoint.
// Holds the command encodings, field widths, idle FSM states and error bit positions.
package tok_ocpl_pkg;

    localparam int unsigned TOK_ADDR_W = 8;
    localparam int unsigned TOK_DATA_W = 8;

    localparam logic [2:0] TOK_MCMD_IDLE = 3'd0;
    localparam logic [2:0] TOK_MCMD_WR   = 3'd1;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StIdle
    } tok_idle_state_e;

    localparam int unsigned ERR_W         = 3;
    localparam int unsigned ERR_ILL_CMD   = 0;
    localparam int unsigned ERR_BAD_ADDR  = 1;
    localparam int unsigned ERR_UNDERFLOW = 2;

endpackage

// File: rtl/tok_ocpl_cnt.sv
// One token line counter: an increment and a single-token consume can land in the same cycle.
// The caller guarantees that the increment fits, so the counter only guards the zero case.
module tok_ocpl_cnt
    import tok_ocpl_pkg::*;
#(
    parameter int unsigned CntW = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  inc_en,
    input  logic [TOK_DATA_W-1:0] inc_val,
    input  logic                  dec,
    output logic [CntW-1:0]       cnt,
    output logic                  avail,
    output logic                  underflow
);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic [CntW-1:0] inc_amt;
    logic            dec_ok;

    always_comb begin
        inc_amt = inc_en ? CntW'(inc_val) : '0;
        dec_ok  = dec && (cnt_q != '0);
        cnt_d   = cnt_q + inc_amt - CntW'(dec_ok);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign avail     = (cnt_q != '0);
    assign underflow = dec && (cnt_q == '0);

endmodule

// File: rtl/tok_ocpl_target.sv
// Block-side terminator of the NoC token link: one-entry hold register feeding per-line
// token counters, with sticky error reporting and the NoC idle request/ack handshake.
module tok_ocpl_target
    import tok_ocpl_pkg::*;
#(
    parameter int unsigned NumTok = 8,
    parameter int unsigned CntW   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [TOK_ADDR_W-1:0] i_tok_ocpl_s_maddr,
    input  logic [2:0]            i_tok_ocpl_s_mcmd,
    input  logic [TOK_DATA_W-1:0] i_tok_ocpl_s_mdata,
    output logic                  o_tok_ocpl_s_scmdaccept,
    output logic [NumTok-1:0]     o_tok_avail,
    input  logic [NumTok-1:0]     i_tok_consume,
    input  logic                  i_idle_req,
    output logic                  o_idle_ack,
    output logic                  o_idle_val,
    output logic [ERR_W-1:0]      o_err,
    input  logic                  i_err_clr
);

    localparam int unsigned SumW = CntW + 1;

    logic                  hold_vld_q;
    logic [TOK_ADDR_W-1:0] hold_addr_q;
    logic [TOK_DATA_W-1:0] hold_data_q;
    tok_idle_state_e       state_q;
    logic                  idle_ack_q;
    logic [ERR_W-1:0]      err_q;
    logic [ERR_W-1:0]      err_d;

    logic [CntW-1:0]   cnt [NumTok];
    logic [CntW-1:0]   sel_cnt;
    logic [SumW-1:0]   sum;
    logic [NumTok-1:0] inc_en;
    logic [NumTok-1:0] underflow;
    logic              addr_ok;
    logic              fits;
    logic              apply;
    logic              discard;
    logic              accept;
    logic              xfer;
    logic              wr;
    logic              illegal;

    // Fit check uses registered counts only, so accept never depends on a live input.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NumTok; i++) begin
            if (hold_addr_q == TOK_ADDR_W'(i)) begin
                sel_cnt = cnt[i];
            end
        end
        addr_ok = 32'(hold_addr_q) < NumTok;
        sum     = {1'b0, sel_cnt} + SumW'(hold_data_q);
        fits    = addr_ok && !sum[CntW];
        apply   = hold_vld_q && fits;
        discard = hold_vld_q && !addr_ok;
        accept  = (state_q == StRun) && (!hold_vld_q || apply || discard);
        xfer    = accept && (i_tok_ocpl_s_mcmd != TOK_MCMD_IDLE);
        wr      = xfer && (i_tok_ocpl_s_mcmd == TOK_MCMD_WR);
        illegal = xfer && (i_tok_ocpl_s_mcmd != TOK_MCMD_WR);
    end

    for (genvar g = 0; g < NumTok; g++) begin : g_line
        assign inc_en[g] = apply && (hold_addr_q == TOK_ADDR_W'(g));

        tok_ocpl_cnt #(
            .CntW (CntW)
        ) u_cnt (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .inc_en    (inc_en[g]),
            .inc_val   (hold_data_q),
            .dec       (i_tok_consume[g]),
            .cnt       (cnt[g]),
            .avail     (o_tok_avail[g]),
            .underflow (underflow[g])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_vld_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else if (wr) begin
            hold_vld_q  <= 1'b1;
            hold_addr_q <= i_tok_ocpl_s_maddr;
            hold_data_q <= i_tok_ocpl_s_mdata;
        end else if (apply || discard) begin
            hold_vld_q  <= 1'b0;
        end
    end

    always_comb begin
        err_d = err_q;
        if (i_err_clr) begin
            err_d = '0;
        end else begin
            err_d[ERR_ILL_CMD]   = err_q[ERR_ILL_CMD] | illegal;
            err_d[ERR_BAD_ADDR]  = err_q[ERR_BAD_ADDR] | discard;
            err_d[ERR_UNDERFLOW] = err_q[ERR_UNDERFLOW] | (|underflow);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StRun;
            idle_ack_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (i_idle_req) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (!i_idle_req) begin
                        state_q <= StRun;
                    end else if (!hold_vld_q) begin
                        state_q    <= StIdle;
                        idle_ack_q <= 1'b1;
                    end
                end
                StIdle: begin
                    if (!i_idle_req) begin
                        state_q    <= StRun;
                        idle_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StRun;
                    idle_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_tok_ocpl_s_scmdaccept = accept;
    assign o_idle_ack              = idle_ack_q;
    assign o_idle_val              = !hold_vld_q && !(|o_tok_avail);
    assign o_err                   = err_q;

endmodule

// File: tb/tb_tok_ocpl_target.sv
// Directed bench for tok_ocpl_target: a per-cycle vector table plus hand-written sequences
// for backpressure, idle handshake, back-to-back writes and reset during a stall.
module tb_tok_ocpl_target;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] maddr = '0;
    logic [2:0] mcmd = '0;
    logic [7:0] mdata = '0;
    logic       accept;
    logic [7:0] avail;
    logic [7:0] consume = '0;
    logic       idle_req = 1'b0;
    logic       idle_ack;
    logic       idle_val;
    logic [2:0] err;
    logic       err_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tok_ocpl_target #(
        .NumTok (8),
        .CntW   (8)
    ) dut (
        .i_clk                   (clk),
        .i_rst_n                 (rst_n),
        .i_tok_ocpl_s_maddr      (maddr),
        .i_tok_ocpl_s_mcmd       (mcmd),
        .i_tok_ocpl_s_mdata      (mdata),
        .o_tok_ocpl_s_scmdaccept (accept),
        .o_tok_avail             (avail),
        .i_tok_consume           (consume),
        .i_idle_req              (idle_req),
        .o_idle_ack              (idle_ack),
        .o_idle_val              (idle_val),
        .o_err                   (err),
        .i_err_clr               (err_clr)
    );

    typedef struct {
        logic [7:0] maddr;
        logic [2:0] mcmd;
        logic [7:0] mdata;
        logic [7:0] consume;
        logic       err_clr;
        logic       exp_accept;
        logic [7:0] exp_avail;
        logic       exp_idle_val;
        logic [2:0] exp_err;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs set before the call are sampled at the next edge; outputs checked 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        maddr    = '0;
        mcmd     = 3'd0;
        mdata    = '0;
        consume  = '0;
        idle_req = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One write transfer; only used when accept is known to be high.
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        maddr = a;
        mdata = d;
        mcmd  = 3'd1;
        step();
        mcmd  = 3'd0;
    endtask

    task automatic consume_n(input int line, input int n);
        for (int k = 0; k < n; k++) begin
            consume = 8'(1 << line);
            step();
        end
        consume = '0;
    endtask

    initial begin
        // Single write to line 3, drain it, then error bits and a zero-data write.
        vecs[0]  = '{8'd3, 3'd1, 8'd5, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'b000};
        vecs[1]  = '{8'd0, 3'd0, 8'd0, 8'h00, 1'b0, 1'b1, 8'h08, 1'b0, 3'b000};
        vecs[2]  = '{8'd0, 3'd0, 8'd0, 8'h08, 1'b0, 1'b1, 8'h08, 1'b0, 3'b000};
        vecs[3]  = '{8'd0, 3'd0, 8'd0, 8'h08, 1'b0, 1'b1, 8'h08, 1'b0, 3'b000};
        vecs[4]  = '{8'd0, 3'd0, 8'd0, 8'h08, 1'b0, 1'b1, 8'h08, 1'b0, 3'b000};
        vecs[5]  = '{8'd0, 3'd0, 8'd0, 8'h08, 1'b0, 1'b1, 8'h08, 1'b0, 3'b000};
        vecs[6]  = '{8'd0, 3'd0, 8'd0, 8'h08, 1'b0, 1'b1, 8'h00, 1'b1, 3'b000};
        vecs[7]  = '{8'd0, 3'd0, 8'd0, 8'h08, 1'b0, 1'b1, 8'h00, 1'b1, 3'b100};
        vecs[8]  = '{8'd0, 3'd5, 8'd9, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 3'b101};
        vecs[9]  = '{8'd8, 3'd1, 8'd1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'b101};
        vecs[10] = '{8'd0, 3'd0, 8'd0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 3'b111};
        vecs[11] = '{8'd0, 3'd0, 8'd0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 3'b000};
        vecs[12] = '{8'd0, 3'd0, 8'd0, 8'h01, 1'b1, 1'b1, 8'h00, 1'b1, 3'b000};
        vecs[13] = '{8'd7, 3'd1, 8'd0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'b000};
        vecs[14] = '{8'd0, 3'd0, 8'd0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 3'b000};

        do_reset();
        #1;
        check("reset accept", 32'(accept), 32'd1);
        check("reset avail", 32'(avail), 32'd0);
        check("reset idle_val", 32'(idle_val), 32'd1);
        check("reset idle_ack", 32'(idle_ack), 32'd0);
        check("reset err", 32'(err), 32'd0);

        for (int i = 0; i < 15; i++) begin
            maddr   = vecs[i].maddr;
            mcmd    = vecs[i].mcmd;
            mdata   = vecs[i].mdata;
            consume = vecs[i].consume;
            err_clr = vecs[i].err_clr;
            step();
            check($sformatf("vec%0d accept", i), 32'(accept), 32'(vecs[i].exp_accept));
            check($sformatf("vec%0d avail", i), 32'(avail), 32'(vecs[i].exp_avail));
            check($sformatf("vec%0d idle_val", i), 32'(idle_val), 32'(vecs[i].exp_idle_val));
            check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
        end
        idle_inputs();

        // Backpressure: 250 + 10 overflows until five consumes leave 245.
        do_reset();
        wr(8'd0, 8'd250);
        step();
        wr(8'd0, 8'd10);
        check("bp stall accept", 32'(accept), 32'd0);
        step();
        check("bp stall hold accept", 32'(accept), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            consume = 8'h01;
            step();
            check($sformatf("bp accept after consume %0d", k), 32'(accept), 32'(k == 5));
        end
        consume = '0;
        step();
        check("bp applied accept", 32'(accept), 32'd1);
        check("bp applied idle_val", 32'(idle_val), 32'd0);
        consume_n(0, 254);
        check("bp cnt0 above 254", 32'(avail), 32'h01);
        consume_n(0, 1);
        check("bp cnt0 exactly 255", 32'(avail), 32'h00);
        check("bp err", 32'(err), 32'd0);

        // Idle request with a stalled entry: no ack until the entry applies.
        do_reset();
        wr(8'd1, 8'd250);
        step();
        wr(8'd1, 8'd10);
        idle_req = 1'b1;
        step();
        check("idle drain accept", 32'(accept), 32'd0);
        check("idle drain ack", 32'(idle_ack), 32'd0);
        step();
        check("idle drain ack held", 32'(idle_ack), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            consume = 8'h02;
            step();
            check($sformatf("idle ack low consume %0d", k), 32'(idle_ack), 32'd0);
        end
        consume = '0;
        begin
            logic got;
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                step();
                got = idle_ack;
            end
            check("idle ack rises", 32'(got), 32'd1);
        end
        check("idle accept low", 32'(accept), 32'd0);
        check("idle_val with 255 tokens", 32'(idle_val), 32'd0);
        idle_req = 1'b0;
        step();
        check("idle release ack", 32'(idle_ack), 32'd0);
        check("idle release accept", 32'(accept), 32'd1);

        // Back-to-back writes 1,2,1 with a consume on line 1 as the last write applies.
        do_reset();
        maddr = 8'd1;
        mdata = 8'd1;
        mcmd  = 3'd1;
        step();
        check("b2b accept 1", 32'(accept), 32'd1);
        maddr = 8'd2;
        step();
        check("b2b accept 2", 32'(accept), 32'd1);
        maddr = 8'd1;
        step();
        check("b2b accept 3", 32'(accept), 32'd1);
        mcmd    = 3'd0;
        consume = 8'h02;
        step();
        consume = '0;
        check("b2b avail", 32'(avail), 32'h06);
        check("b2b err", 32'(err), 32'd0);
        consume = 8'h06;
        step();
        check("b2b drained", 32'(avail), 32'h00);
        check("b2b no underflow", 32'(err), 32'd0);
        consume = 8'h02;
        step();
        consume = '0;
        check("b2b line1 was one", 32'(err), 32'b100);

        // Reset asserted mid-stall drops the hold entry and clears counters.
        do_reset();
        wr(8'd0, 8'd250);
        step();
        wr(8'd0, 8'd10);
        check("rst stall accept", 32'(accept), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst avail", 32'(avail), 32'd0);
        check("rst idle_val", 32'(idle_val), 32'd1);
        check("rst accept", 32'(accept), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst after accept", 32'(accept), 32'd1);
        check("rst after avail", 32'(avail), 32'd0);
        check("rst after idle_val", 32'(idle_val), 32'd1);
        check("rst after err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
